// File: rtl/onehot_grant_pkg.sv
// Shared types and constants for the one-hot grant decoder.
// The optional per-line hit counters are enabled with ONEHOT_GRANT_HIT_CNT_EN.
package onehot_grant_pkg;

  localparam int NUM_LINES = 8;
  localparam int CODE_W    = 3;

  typedef logic [CODE_W-1:0]    code_t;
  typedef logic [NUM_LINES-1:0] onehot_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Binary line index to one-hot grant vector.
  function automatic onehot_t code_to_onehot(code_t code);
    onehot_t vec;
    vec       = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/grant_skid_buf.sv
// One-entry skid buffer for grant codes. Upstream ready depends only on the
// registered full flag, so it never forms a combinational path to the sink.
module grant_skid_buf
  import onehot_grant_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  s_valid,
  output logic  s_ready,
  input  code_t s_data,
  output logic  m_valid,
  input  logic  m_ready,
  output code_t m_data
);

  logic  full_q;
  code_t data_q;

  assign s_ready = !full_q;
  assign m_valid = full_q;
  assign m_data  = data_q;

  // Capture on push, release on pop; push and pop never coincide because
  // a push needs the entry empty and a pop needs it full.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (s_valid && s_ready) begin
      full_q <= 1'b1;
      data_q <= s_data;
    end else if (m_valid && m_ready) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/onehot_grant_decoder.sv
// Decodes accepted 3-bit line indices into registered one-hot grants with a
// valid/ready handshake on both sides, a one-entry skid buffer and an
// optional idle gap (GAP_CYCLES) after every completed output transfer.
// Define ONEHOT_GRANT_HIT_CNT_EN to add saturating per-line completion counters.
module onehot_grant_decoder
  import onehot_grant_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_onehot,
  output logic [2:0]  out_code
`ifdef ONEHOT_GRANT_HIT_CNT_EN
  ,
  input  logic [2:0]  hit_cnt_sel,
  output logic [7:0]  hit_cnt
`endif
);

  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t     state_q;
  logic       out_valid_q;
  code_t      out_code_q;
  onehot_t    out_onehot_q;
  logic [3:0] gap_cnt_q;

  logic  accept;
  logic  skid_valid;
  code_t skid_data;
  logic  skid_push;
  logic  skid_pop;
  logic  slot_open;
  logic  load_in;
  logic  load;
  code_t code_d;

  assign accept    = in_valid && in_ready;
  assign skid_push = accept && !load_in;

  grant_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (skid_push),
    .s_ready (in_ready),
    .s_data  (in_code),
    .m_valid (skid_valid),
    .m_ready (skid_pop),
    .m_data  (skid_data)
  );

  // Decide whether the output register can take a new item this cycle and
  // where it comes from; the skid entry always goes before a fresh input.
  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    slot_open = 1'b0;
    skid_pop  = 1'b0;
    load_in   = 1'b0;
    unique case (state_q)
      IDLE:    slot_open = 1'b1;
      DRIVE:   slot_open = out_ready && (GAP_CYCLES == 0);
      GAP:     slot_open = (gap_cnt_q == GAP_LAST);
      default: slot_open = 1'b0;
    endcase
    if (slot_open) begin
      if (skid_valid) skid_pop = 1'b1;
      else            load_in  = accept;
    end
    load   = skid_pop || load_in;
    code_d = skid_pop ? skid_data : in_code;
  end

  // Output FSM: registered valid, code and one-hot grant plus gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_code_q   <= '0;
      out_onehot_q <= '0;
      gap_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            state_q      <= DRIVE;
            out_valid_q  <= 1'b1;
            out_code_q   <= code_d;
            out_onehot_q <= code_to_onehot(code_d);
          end
        end
        DRIVE: begin
          if (out_ready) begin
            if (load) begin
              out_code_q   <= code_d;
              out_onehot_q <= code_to_onehot(code_d);
            end else begin
              out_valid_q  <= 1'b0;
              out_code_q   <= '0;
              out_onehot_q <= '0;
              gap_cnt_q    <= '0;
              state_q      <= (GAP_CYCLES == 0) ? IDLE : GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q <= '0;
            if (load) begin
              state_q      <= DRIVE;
              out_valid_q  <= 1'b1;
              out_code_q   <= code_d;
              out_onehot_q <= code_to_onehot(code_d);
            end else begin
              state_q <= IDLE;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_code   = out_code_q;
  assign out_onehot = out_onehot_q;

`ifdef ONEHOT_GRANT_HIT_CNT_EN
  logic [7:0] hit_cnt_q [NUM_LINES];

  // Count completed transfers per line, saturating at 255.
  // NOTE: this small register array holds architectural counts, so it is
  // reset entry by entry rather than left as uninitialised storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LINES; i++) hit_cnt_q[i] <= '0;
    end else if (out_valid_q && out_ready && (hit_cnt_q[out_code_q] != 8'hFF)) begin
      hit_cnt_q[out_code_q] <= hit_cnt_q[out_code_q] + 8'd1;
    end
  end

  assign hit_cnt = hit_cnt_q[hit_cnt_sel];
`endif

endmodule

// File: tb/tb_onehot_grant_decoder.sv
// Self-checking bench for onehot_grant_decoder: a GAP_CYCLES=0 instance and a
// GAP_CYCLES=3 instance, cycle vectors, hand-written corner sequences and a
// queue scoreboard per instance. Counter checks run when
// ONEHOT_GRANT_HIT_CNT_EN is defined.
module tb_onehot_grant_decoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready;
  logic [2:0] in_code, out_code;
  logic [7:0] out_onehot;

  logic       g_in_valid, g_in_ready, g_out_valid, g_out_ready;
  logic [2:0] g_in_code, g_out_code;
  logic [7:0] g_out_onehot;

`ifdef ONEHOT_GRANT_HIT_CNT_EN
  logic [2:0] hit_cnt_sel, g_hit_cnt_sel;
  logic [7:0] hit_cnt, g_hit_cnt;
`endif

  onehot_grant_decoder #(.GAP_CYCLES(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_code   (out_code)
`ifdef ONEHOT_GRANT_HIT_CNT_EN
    ,
    .hit_cnt_sel(hit_cnt_sel),
    .hit_cnt    (hit_cnt)
`endif
  );

  onehot_grant_decoder #(.GAP_CYCLES(3)) dut_gap (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (g_in_valid),
    .in_ready   (g_in_ready),
    .in_code    (g_in_code),
    .out_valid  (g_out_valid),
    .out_ready  (g_out_ready),
    .out_onehot (g_out_onehot),
    .out_code   (g_out_code)
`ifdef ONEHOT_GRANT_HIT_CNT_EN
    ,
    .hit_cnt_sel(g_hit_cnt_sel),
    .hit_cnt    (g_hit_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboards: codes pushed on accept, popped on completion.
  logic [2:0] sb0[$];
  logic [2:0] sbg[$];
  logic [2:0] exp0, expg;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb0.delete();
      sbg.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb0.size() == 0) begin
          check("sb0_unexpected_output", 32'(sb0.size()), 32'd1);
        end else begin
          exp0 = sb0.pop_front();
          check("sb0_onehot", out_onehot, 8'h01 << exp0);
          check("sb0_code", out_code, exp0);
        end
      end
      if (in_valid && in_ready) sb0.push_back(in_code);
      if (g_out_valid && g_out_ready) begin
        if (sbg.size() == 0) begin
          check("sbg_unexpected_output", 32'(sbg.size()), 32'd1);
        end else begin
          expg = sbg.pop_front();
          check("sbg_onehot", g_out_onehot, 8'h01 << expg);
          check("sbg_code", g_out_code, expg);
        end
      end
      if (g_in_valid && g_in_ready) sbg.push_back(g_in_code);
      if (!out_valid) begin
        check("idle0_onehot", out_onehot, 8'h00);
        check("idle0_code", out_code, 3'd0);
      end
      if (!g_out_valid) begin
        check("idleg_onehot", g_out_onehot, 8'h00);
        check("idleg_code", g_out_code, 3'd0);
      end
    end
  end

  typedef struct packed {
    logic       iv;
    logic [2:0] ic;
    logic       ordy;
    logic       ov;
    logic [7:0] oh;
    logic [2:0] oc;
    logic       ir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [2:0] ic, logic ordy,
                              logic ov, logic [7:0] oh, logic [2:0] oc, logic ir);
    vec_t v;
    v.iv = iv; v.ic = ic; v.ordy = ordy;
    v.ov = ov; v.oh = oh; v.oc = oc; v.ir = ir;
    return v;
  endfunction

  // Gap-instance expectations for codes 1 then 6 back-to-back.
  logic       gap_iv [7] = '{1, 1, 0, 0, 0, 0, 0};
  logic [2:0] gap_ic [7] = '{3'd1, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
  logic       gap_ov [7] = '{0, 1, 0, 0, 0, 1, 0};
  logic [7:0] gap_oh [7] = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00};
  logic       gap_ir [7] = '{1, 1, 0, 0, 0, 1, 1};

  initial begin
    int drained;
    rst_n = 1'b0;
    in_valid = 1'b1; in_code = 3'd4; out_ready = 1'b1;
    g_in_valid = 1'b0; g_in_code = 3'd0; g_out_ready = 1'b1;
`ifdef ONEHOT_GRANT_HIT_CNT_EN
    hit_cnt_sel = 3'd0; g_hit_cnt_sel = 3'd0;
`endif

    // Reset state, with an input offered during reset that must be dropped.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_onehot", out_onehot, 8'h00);
    check("rst_out_code", out_code, 3'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // REQ-031 style single item, with X on in_code while idle.
    vecs.push_back(mk(1, 3'd5, 1, 0, 8'h00, 3'd0, 1));
    vecs.push_back(mk(0, 3'bxxx, 1, 1, 8'h20, 3'd5, 1));
    vecs.push_back(mk(0, 3'bxxx, 1, 0, 8'h00, 3'd0, 1));
    // Back-to-back codes 0..7 at full throughput.
    for (int i = 0; i < 9; i++) begin
      logic [2:0] c;
      logic [2:0] p;
      c = 3'(i);
      p = 3'(i - 1);
      vecs.push_back(mk(i < 8, c, 1, i > 0, (i > 0) ? (8'h01 << p) : 8'h00,
                        (i > 0) ? p : 3'd0, 1));
    end
    vecs.push_back(mk(0, 3'd0, 1, 0, 8'h00, 3'd0, 1));
    // Stall: 2 held, 3 in skid, 4 blocked, then released in order.
    vecs.push_back(mk(1, 3'd2, 0, 0, 8'h00, 3'd0, 1));
    vecs.push_back(mk(1, 3'd3, 0, 1, 8'h04, 3'd2, 1));
    vecs.push_back(mk(1, 3'd4, 0, 1, 8'h04, 3'd2, 0));
    vecs.push_back(mk(1, 3'd4, 0, 1, 8'h04, 3'd2, 0));
    vecs.push_back(mk(1, 3'd4, 1, 1, 8'h04, 3'd2, 0));
    vecs.push_back(mk(1, 3'd4, 1, 1, 8'h08, 3'd3, 1));
    vecs.push_back(mk(0, 3'd0, 1, 1, 8'h10, 3'd4, 1));
    vecs.push_back(mk(0, 3'd0, 1, 0, 8'h00, 3'd0, 1));

    foreach (vecs[k]) begin
      in_valid = vecs[k].iv; in_code = vecs[k].ic; out_ready = vecs[k].ordy;
      @(negedge clk);
      check($sformatf("vec%0d_out_valid", k), out_valid, vecs[k].ov);
      check($sformatf("vec%0d_out_onehot", k), out_onehot, vecs[k].oh);
      check($sformatf("vec%0d_out_code", k), out_code, vecs[k].oc);
      check($sformatf("vec%0d_in_ready", k), in_ready, vecs[k].ir);
      @(posedge clk); #1;
    end

    // Reset while DRIVE with the skid full.
    in_valid = 1'b1; in_code = 3'd1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_code = 3'd2;
    @(posedge clk); #1;
    in_code = 3'd3;
    @(negedge clk);
    check("pre_rst_in_ready", in_ready, 1'b0);
    check("pre_rst_out_onehot", out_onehot, 8'h02);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_onehot", out_onehot, 8'h00);
    check("mid_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_out_valid", out_valid, 1'b0);
      check("post_rst_in_ready", in_ready, 1'b1);
    end
    @(posedge clk); #1;

    // GAP_CYCLES=3: 8'h02, three idle cycles, then 8'h40.
    for (int i = 0; i < 7; i++) begin
      g_in_valid = gap_iv[i]; g_in_code = gap_ic[i]; g_out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("gap%0d_out_valid", i), g_out_valid, gap_ov[i]);
      check($sformatf("gap%0d_out_onehot", i), g_out_onehot, gap_oh[i]);
      check($sformatf("gap%0d_in_ready", i), g_in_ready, gap_ir[i]);
      @(posedge clk); #1;
    end

    // Random traffic on both instances; scoreboards check order and data.
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_code     = 3'($urandom_range(0, 7));
      out_ready   = ($urandom_range(0, 2) != 0);
      g_in_valid  = ($urandom_range(0, 1) != 0);
      g_in_code   = 3'($urandom_range(0, 7));
      g_out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; g_in_valid = 1'b0; out_ready = 1'b1; g_out_ready = 1'b1;
    drained = 0;
    for (int i = 0; i < 100 && !drained; i++) begin
      @(negedge clk);
      if (sb0.size() == 0 && sbg.size() == 0 && !out_valid && !g_out_valid) drained = 1;
    end
    check("drain_sb0_empty", 32'(sb0.size()), 32'd0);
    check("drain_sbg_empty", 32'(sbg.size()), 32'd0);
    check("drain_out_valid", out_valid, 1'b0);
    check("drain_g_out_valid", g_out_valid, 1'b0);

`ifdef ONEHOT_GRANT_HIT_CNT_EN
    // 300 completions of line 7 saturate its counter; others stay zero.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_code = 3'd7; out_ready = 1'b1;
    repeat (300) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 8; i++) begin
      hit_cnt_sel = 3'(i);
      #1;
      check($sformatf("hit_cnt_line%0d", i), hit_cnt, (i == 7) ? 8'd255 : 8'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
